// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_core
// Brief    : Multicycle MIPS-subset core with req/ready instruction/data ports
// Revision : 1.0  initial release
// ============================================================================
module mips_multicycle_core #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                NUM_REGS = 32
) (
    input  logic              i_clk,
    input  logic              i_arst,
    output logic              o_imem_req,
    output logic [XLEN-1:0]   o_imem_addr,
    input  logic              i_imem_ready,
    input  logic [31:0]       i_imem_data,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_ready,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    output logic [31:0]       o_instruction,
    output logic [XLEN-1:0]   o_cur_pc,
    output logic [XLEN-1:0]   o_next_pc,
    output logic              o_retire,
    output logic              o_halt
);

    localparam int RW = $clog2(NUM_REGS);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    localparam logic [XLEN-1:0] c_four = XLEN'(4);

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_regs [NUM_REGS];

    logic [5:0]      w_op;
    logic [5:0]      w_funct;
    logic [RW-1:0]   w_rs;
    logic [RW-1:0]   w_rt;
    logic [RW-1:0]   w_rd;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_j_target;
    logic [XLEN-1:0] w_alu;
    logic            w_is_r;
    logic            w_is_j;
    logic            w_is_beq;
    logic            w_is_bne;
    logic            w_is_addi;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_r_ok;
    logic            w_legal;
    logic            w_taken;
    logic            w_rf_we;
    logic [RW-1:0]   w_rf_waddr;
    logic [XLEN-1:0] w_rf_wdata;

    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_rs      = r_ir[21 +: RW];
    assign w_rt      = r_ir[16 +: RW];
    assign w_rd      = r_ir[11 +: RW];
    assign w_imm     = {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};

    assign w_is_r    = (w_op == c_op_rtype);
    assign w_is_j    = (w_op == c_op_j);
    assign w_is_beq  = (w_op == c_op_beq);
    assign w_is_bne  = (w_op == c_op_bne);
    assign w_is_addi = (w_op == c_op_addi);
    assign w_is_lw   = (w_op == c_op_lw);
    assign w_is_sw   = (w_op == c_op_sw);
    assign w_r_ok    = (w_funct == c_fn_add) || (w_funct == c_fn_sub) || (w_funct == c_fn_and) ||
                       (w_funct == c_fn_or)  || (w_funct == c_fn_slt);
    assign w_legal   = (w_is_r && w_r_ok) || w_is_j || w_is_beq || w_is_bne ||
                       w_is_addi || w_is_lw || w_is_sw;

    assign w_pc_plus4  = r_pc + c_four;
    assign w_br_target = w_pc_plus4 + (w_imm << 2);
    assign w_j_target  = {w_pc_plus4[XLEN-1:28], r_ir[25:0], 2'b00};
    assign w_taken     = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));

    // Non-R-type users of the ALU (addi, lw, sw) all need base + sign-extended offset.
    always_comb begin
        w_alu = r_a + w_imm;
        if (w_is_r) begin
            case (w_funct)
                c_fn_sub: w_alu = r_a - r_b;
                c_fn_and: w_alu = r_a & r_b;
                c_fn_or:  w_alu = r_a | r_b;
                c_fn_slt: w_alu = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                default:  w_alu = r_a + r_b;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_fetch:  if (i_imem_ready) w_state_next = c_st_decode;
            c_st_decode: w_state_next = w_legal ? c_st_exec : c_st_halt;
            c_st_exec: begin
                if (w_is_r || w_is_addi)    w_state_next = c_st_wb;
                else if (w_is_lw || w_is_sw) w_state_next = c_st_mem;
                else                         w_state_next = c_st_fetch;
            end
            c_st_mem:    if (i_dmem_ready) w_state_next = w_is_lw ? c_st_wb : c_st_fetch;
            c_st_wb:     w_state_next = c_st_fetch;
            c_st_halt:   w_state_next = c_st_halt;
            default:     w_state_next = c_st_halt;
        endcase
    end

    // Reset lands the state in FETCH, so the fetch request is masked while reset is held.
    always_comb begin
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_retire   = 1'b0;
        o_halt     = 1'b0;
        o_next_pc  = w_pc_plus4;
        w_rf_we    = 1'b0;
        w_rf_waddr = w_is_r ? w_rd : w_rt;
        w_rf_wdata = w_is_lw ? r_mdr : r_alu;
        case (r_state)
            c_st_fetch: o_imem_req = ~i_arst;
            c_st_exec: begin
                if (w_is_j) begin
                    o_retire  = 1'b1;
                    o_next_pc = w_j_target;
                end else if (w_is_beq || w_is_bne) begin
                    o_retire = 1'b1;
                    if (w_taken) o_next_pc = w_br_target;
                end
            end
            c_st_mem: begin
                o_dmem_req = 1'b1;
                o_retire   = i_dmem_ready && w_is_sw;
            end
            c_st_wb: begin
                o_retire = 1'b1;
                w_rf_we  = 1'b1;
            end
            c_st_halt: o_halt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_mdr <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (r_state == c_st_fetch && i_imem_ready) r_ir <= i_imem_data;
            if (r_state == c_st_decode) begin
                r_a <= (w_rs == '0) ? '0 : r_regs[w_rs];
                r_b <= (w_rt == '0) ? '0 : r_regs[w_rt];
            end
            if (r_state == c_st_exec) r_alu <= w_alu;
            if (r_state == c_st_mem && i_dmem_ready && w_is_lw) r_mdr <= i_dmem_rdata;
            if (o_retire) r_pc <= o_next_pc;
            if (w_rf_we && (w_rf_waddr != '0)) r_regs[w_rf_waddr] <= w_rf_wdata;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_dmem_we     = w_is_sw;
    assign o_dmem_addr   = r_alu;
    assign o_dmem_wdata  = r_b;
    assign o_instruction = r_ir;
    assign o_cur_pc      = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_core
// Brief    : Scoreboard bench: directed program, wait-state memory models
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_multicycle_core;

    localparam logic [31:0] c_rpc = 32'h0000_0100;

    typedef struct { logic [31:0] pc; logic [31:0] npc; int lat; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

    logic        i_clk = 1'b0;
    logic        i_arst = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready = 1'b0;
    logic [31:0] i_imem_data = '0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ready = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic [31:0] o_instruction;
    logic [31:0] o_cur_pc;
    logic [31:0] o_next_pc;
    logic        o_retire;
    logic        o_halt;

    mips_multicycle_core #(.XLEN(32), .RESET_PC(c_rpc), .NUM_REGS(32)) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_data(i_imem_data),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rdata(i_dmem_rdata),
        .o_instruction(o_instruction), .o_cur_pc(o_cur_pc),
        .o_next_pc(o_next_pc), .o_retire(o_retire), .o_halt(o_halt)
    );

    always #5 i_clk = ~i_clk;

    logic [31:0] imem [128];
    logic [31:0] dmem [16];
    int iw_cnt = 0;
    int dw_cnt = 0;

    ret_t ret_q[$];
    st_t  st_q[$];
    int   checks = 0;
    int   passes = 0;
    int   both_req_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int imem_wait(input logic [31:0] a);
        return (a == 32'h154) ? 2 : 0;
    endfunction

    function automatic int dmem_wait(input logic [31:0] a);
        if (a == 32'd8)  return 3;
        if (a == 32'd40) return 10;
        return 0;
    endfunction

    // Memory models respond on the falling edge so the core samples them at the next rising edge.
    always @(negedge i_clk) begin
        if (o_imem_req) begin
            if (iw_cnt >= imem_wait(o_imem_addr)) begin
                i_imem_ready = 1'b1;
                i_imem_data  = imem[o_imem_addr[8:2]];
                iw_cnt       = 0;
            end else begin
                i_imem_ready = 1'b0;
                iw_cnt++;
            end
        end else begin
            i_imem_ready = 1'b0;
            iw_cnt       = 0;
        end
        if (o_dmem_req) begin
            if (dw_cnt >= dmem_wait(o_dmem_addr)) begin
                i_dmem_ready = 1'b1;
                i_dmem_rdata = dmem[o_dmem_addr[5:2]];
                if (o_dmem_we) dmem[o_dmem_addr[5:2]] = o_dmem_wdata;
                dw_cnt = 0;
            end else begin
                i_dmem_ready = 1'b0;
                dw_cnt++;
            end
        end else begin
            i_dmem_ready = 1'b0;
            dw_cnt       = 0;
        end
    end

    // Monitor: pops the scoreboard on every retire and every completed store.
    int          cyc = 0;
    int          fstart = 0;
    int          cap_cyc = 0;
    logic        prev_ireq = 1'b0;
    logic        d_pending = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;
    always begin
        @(negedge i_clk);
        #1;
        cyc++;
        if (i_arst) begin
            prev_ireq = 1'b0;
            d_pending = 1'b0;
        end else begin
            if (o_imem_req && o_dmem_req) both_req_bad++;
            if (o_imem_req && !prev_ireq) fstart = cyc;
            prev_ireq = o_imem_req;
            if (o_dmem_req && !d_pending) begin
                cap_cyc   = cyc;
                cap_addr  = o_dmem_addr;
                cap_wdata = o_dmem_wdata;
                cap_we    = o_dmem_we;
            end
            if (o_dmem_req && i_dmem_ready) begin
                if (cyc != cap_cyc) begin
                    chk("dmem_addr_stable", o_dmem_addr, cap_addr);
                    chk("dmem_wdata_stable", o_dmem_wdata, cap_wdata);
                    chk("dmem_we_stable", 32'(o_dmem_we), 32'(cap_we));
                end
                if (o_dmem_we) begin
                    if (st_q.size() == 0) begin
                        checks++;
                        $display("FAIL store_unexpected: got addr %h data %h expected none", o_dmem_addr, o_dmem_wdata);
                    end else begin
                        st_t s;
                        s = st_q.pop_front();
                        chk("store_addr", o_dmem_addr, s.addr);
                        chk("store_data", o_dmem_wdata, s.data);
                    end
                end
            end
            d_pending = o_dmem_req && !i_dmem_ready;
            if (o_retire) begin
                if (ret_q.size() == 0) begin
                    checks++;
                    $display("FAIL retire_unexpected: got pc %h next %h expected none", o_cur_pc, o_next_pc);
                end else begin
                    ret_t r;
                    r = ret_q.pop_front();
                    chk("retire_pc", o_cur_pc, r.pc);
                    chk("retire_next_pc", o_next_pc, r.npc);
                    chk("retire_latency", 32'(cyc - fstart + 1), 32'(r.lat));
                end
            end
        end
    end

    task automatic ld(input logic [31:0] a, input logic [31:0] ins, input logic [31:0] npc, input int lat);
        ret_t r;
        imem[a[8:2]] = ins;
        r.pc = a; r.npc = npc; r.lat = lat;
        ret_q.push_back(r);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        st_t s;
        s.addr = a; s.data = d;
        st_q.push_back(s);
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 128; i++) imem[i] = 32'hFC00_0000;
        for (int i = 0; i < 16; i++)  dmem[i] = '0;
        dmem[5] = 32'h7FFF_FFFF;

        ld(32'h100, 32'h2001_0005, 32'h104, 4);  // addi $1,$0,5
        ld(32'h104, 32'h2002_FFFD, 32'h108, 4);  // addi $2,$0,-3
        ld(32'h108, 32'h0022_1820, 32'h10C, 4);  // add  $3,$1,$2
        ld(32'h10C, 32'h0041_202A, 32'h110, 4);  // slt  $4,$2,$1
        ld(32'h110, 32'h0022_4822, 32'h114, 4);  // sub  $9,$1,$2
        ld(32'h114, 32'h0022_5025, 32'h118, 4);  // or   $10,$1,$2
        ld(32'h118, 32'h0022_5824, 32'h11C, 4);  // and  $11,$1,$2
        ld(32'h11C, 32'hAC03_0000, 32'h120, 4);  st(32'd0,  32'd2);
        ld(32'h120, 32'hAC04_0004, 32'h124, 4);  st(32'd4,  32'd1);
        ld(32'h124, 32'hAC09_001C, 32'h128, 4);  st(32'd28, 32'd8);
        ld(32'h128, 32'hAC0A_0020, 32'h12C, 4);  st(32'd32, 32'hFFFF_FFFD);
        ld(32'h12C, 32'hAC0B_0024, 32'h130, 4);  st(32'd36, 32'd5);
        ld(32'h130, 32'hAC01_0008, 32'h134, 7);  st(32'd8,  32'd5);
        ld(32'h134, 32'h8C05_0008, 32'h138, 8);  // lw $5,8($0), 3 wait states
        ld(32'h138, 32'hAC05_000C, 32'h13C, 4);  st(32'd12, 32'd5);
        ld(32'h13C, 32'h2000_0007, 32'h140, 4);  // addi $0,$0,7
        ld(32'h140, 32'h0000_3020, 32'h144, 4);  // add  $6,$0,$0
        ld(32'h144, 32'hAC06_0010, 32'h148, 4);  st(32'd16, 32'd0);
        ld(32'h148, 32'h8C07_0014, 32'h14C, 5);  // lw $7,20($0)
        ld(32'h14C, 32'h20E8_0001, 32'h150, 4);  // addi $8,$7,1
        ld(32'h150, 32'hAC08_0018, 32'h154, 4);  st(32'd24, 32'h8000_0000);
        ld(32'h154, 32'h1421_0004, 32'h158, 5);  // bne $1,$1,4 (2 fetch waits)
        ld(32'h158, 32'h0800_0004, 32'h010, 3);  // j 0x4
        ld(32'h010, 32'h1021_FFFF, 32'h010, 3);  // beq $1,$1,-1
        ld(32'h010, 32'h1021_FFFF, 32'h010, 3);

        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_imem_req", 32'(o_imem_req), 32'd0);
        chk("rst_dmem_req", 32'(o_dmem_req), 32'd0);
        chk("rst_retire", 32'(o_retire), 32'd0);
        chk("rst_halt", 32'(o_halt), 32'd0);
        chk("rst_ir", o_instruction, 32'd0);
        chk("rst_pc", o_cur_pc, c_rpc);

        @(posedge i_clk); #2;
        i_arst = 1'b0;
        #1;
        chk("first_fetch_req", 32'(o_imem_req), 32'd1);
        chk("first_fetch_addr", o_imem_addr, c_rpc);

        for (int i = 0; i < 2000 && (ret_q.size() != 0 || st_q.size() != 0); i++) begin
            @(negedge i_clk); #2;
        end
        chk("program_drained", 32'(ret_q.size() + st_q.size()), 32'd0);
        i_arst = 1'b1;

        // Reset asserted while a store is stalled in MEM.
        imem[64] = 32'hAC01_0028;
        repeat (2) @(negedge i_clk);
        @(posedge i_clk); #2;
        i_arst = 1'b0;
        for (int i = 0; i < 50 && !o_dmem_req; i++) begin
            @(negedge i_clk); #2;
        end
        chk("mem_reached", 32'(o_dmem_req), 32'd1);
        repeat (2) @(negedge i_clk);
        #2;
        i_arst = 1'b1;
        #1;
        chk("arst_dmem_req_drop", 32'(o_dmem_req), 32'd0);
        chk("arst_imem_req_low", 32'(o_imem_req), 32'd0);
        chk("arst_pc", o_cur_pc, c_rpc);

        // Illegal opcode 0x3F halts after decode.
        imem[64] = 32'hFC00_0000;
        repeat (2) @(negedge i_clk);
        @(posedge i_clk); #2;
        i_arst = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !o_halt; i++) begin
            @(negedge i_clk); #2;
            n++;
        end
        chk("halt_asserted", 32'(o_halt), 32'd1);
        chk("halt_latency", 32'(n), 32'd3);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk); #2;
            if (o_imem_req || o_dmem_req || o_retire || !o_halt) bad++;
        end
        chk("halt_quiet", 32'(bad), 32'd0);
        chk("halt_pc_frozen", o_cur_pc, c_rpc);
        chk("halt_ir", o_instruction, 32'hFC00_0000);
        i_arst = 1'b1;
        #1;
        chk("halt_cleared_by_reset", 32'(o_halt), 32'd0);
        chk("no_dual_req", 32'(both_req_bad), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
